// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, LFSR taps and playfield constants
//
// Purpose: common definitions for the level controller and its reverse-pattern LFSR.
// Contents: state_t encoding, LFSR tap mask and step function, tile/row constants.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_RESPAWN   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    // Feedback taps on bits 3 and 2 give the maximal 15-state sequence.
    localparam logic [3:0] LFSR_TAPS        = 4'b1100;
    localparam int         TILE_SIZE        = 32;
    localparam int         NUM_ROWS         = 15;
    localparam int         GOAL_ROW_DEFAULT = 0;

    function automatic logic [3:0] lfsr_next(input logic [3:0] value);
        return {value[2:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reverse_lfsr.sv
// rtl/reverse_lfsr.sv - 4-bit Fibonacci LFSR producing the per-lane reverse pattern
//
// Purpose: holds the lane-direction pattern; load has priority over step.
// Ports:
//   i_Clk, i_Rst  clock and asynchronous active-high reset (loads SEED)
//   i_Load        load i_Seed
//   i_Step        advance one LFSR step
//   i_Seed        value to load
//   o_Value       current LFSR state (registered)
module reverse_lfsr
    import game_pkg::*;
#(
    parameter logic [3:0] SEED = 4'b1001
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Load,
    input  logic       i_Step,
    input  logic [3:0] i_Seed,
    output logic [3:0] o_Value
);

    logic [3:0] r_Value;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Value <= SEED;
        end else if (i_Load) begin
            r_Value <= i_Seed;
        end else if (i_Step) begin
            r_Value <= lfsr_next(r_Value);
        end
    end

    assign o_Value = r_Value;

endmodule

// File: rtl/level_controller.sv
// rtl/level_controller.sv - play/respawn/game-over sequencer with score, lives and lane reversal
//
// Purpose: tracks game progress from frog row, collision and start button and
// drives the obstacle stage (score, level-up pulse, reverse pattern).
// Ports:
//   i_Clk, i_Rst   clock and asynchronous active-high reset
//   i_Start        debounced start button (edge-detected internally)
//   i_Frog_Row     frog tile row
//   i_Collision    frog/car overlap flag
//   o_Score        saturating score
//   o_Level_Up     one-cycle pulse on game start and on each goal
//   o_Reverse      per-lane direction pattern
//   o_Lives        remaining lives
//   o_Frog_Reset   one-cycle pulse returning the frog to its start row
//   o_Game_Over    high while in GAME_OVER
//   o_State        current state encoding
module level_controller
    import game_pkg::*;
#(
    parameter int                  NUM_BITS    = 4,
    parameter logic [NUM_BITS-1:0] LFSR_SEED   = 4'b1001,
    parameter int                  LIVES       = 3,
    parameter int                  GOAL_ROW    = GOAL_ROW_DEFAULT,
    parameter int                  HOLD_CYCLES = 12500000,
    parameter int                  MAX_SCORE   = 15
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start,
    input  logic [3:0]          i_Frog_Row,
    input  logic                i_Collision,
    output logic [3:0]          o_Score,
    output logic                o_Level_Up,
    output logic [NUM_BITS-1:0] o_Reverse,
    output logic [1:0]          o_Lives,
    output logic                o_Frog_Reset,
    output logic                o_Game_Over,
    output logic [1:0]          o_State
);

    localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);

    state_t      r_State;
    logic [3:0]  r_Score;
    logic [1:0]  r_Lives;
    logic [23:0] r_Hold;
    logic        r_Level_Up;
    logic        r_Frog_Reset;
    logic        r_Game_Over;
    logic        r_Start_Prev;

    state_t      w_Next_State;
    logic [3:0]  w_Score_Next;
    logic [1:0]  w_Lives_Next;
    logic [23:0] w_Hold_Next;
    logic        w_Load;
    logic        w_Step;
    logic        w_Level_Up;
    logic        w_Frog_Reset;
    logic        w_Start_Edge;
    logic        w_Goal;
    logic [1:0]  w_Lives_Dec;

    assign w_Start_Edge = i_Start & ~r_Start_Prev;
    assign w_Goal       = (i_Frog_Row == 4'(GOAL_ROW));
    assign w_Lives_Dec  = r_Lives - 2'd1;

    reverse_lfsr #(
        .SEED (LFSR_SEED)
    ) u_reverse_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Load  (w_Load),
        .i_Step  (w_Step),
        .i_Seed  (LFSR_SEED),
        .o_Value (o_Reverse)
    );

    always_comb begin
        w_Next_State = r_State;
        w_Score_Next = r_Score;
        w_Lives_Next = r_Lives;
        w_Hold_Next  = r_Hold;
        w_Load       = 1'b0;
        w_Step       = 1'b0;
        w_Level_Up   = 1'b0;
        w_Frog_Reset = 1'b0;
        case (r_State)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_Start_Edge) begin
                    w_Score_Next = 4'd0;
                    w_Lives_Next = 2'(LIVES);
                    w_Load       = 1'b1;
                    w_Level_Up   = 1'b1;
                    w_Frog_Reset = 1'b1;
                    w_Next_State = ST_RESPAWN;
                end
            end
            ST_PLAY: begin
                // Collision takes precedence; a simultaneous goal is discarded.
                if (i_Collision) begin
                    w_Lives_Next = w_Lives_Dec;
                    if (w_Lives_Dec == 2'd0) begin
                        w_Next_State = ST_GAME_OVER;
                    end else begin
                        w_Frog_Reset = 1'b1;
                        w_Next_State = ST_RESPAWN;
                    end
                end else if (w_Goal) begin
                    w_Score_Next = (r_Score == 4'(MAX_SCORE)) ? r_Score : r_Score + 4'd1;
                    w_Step       = 1'b1;
                    w_Level_Up   = 1'b1;
                    w_Frog_Reset = 1'b1;
                    w_Next_State = ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                if (r_Hold == HOLD_LAST) begin
                    w_Hold_Next  = 24'd0;
                    w_Next_State = ST_PLAY;
                end else begin
                    w_Hold_Next = r_Hold + 24'd1;
                end
            end
            default: w_Next_State = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State      <= ST_IDLE;
            r_Score      <= 4'd0;
            r_Lives      <= 2'(LIVES);
            r_Hold       <= 24'd0;
            r_Level_Up   <= 1'b0;
            r_Frog_Reset <= 1'b0;
            r_Game_Over  <= 1'b0;
            r_Start_Prev <= 1'b0;
        end else begin
            r_State      <= w_Next_State;
            r_Score      <= w_Score_Next;
            r_Lives      <= w_Lives_Next;
            r_Hold       <= w_Hold_Next;
            r_Level_Up   <= w_Level_Up;
            r_Frog_Reset <= w_Frog_Reset;
            r_Game_Over  <= (w_Next_State == ST_GAME_OVER);
            r_Start_Prev <= i_Start;
        end
    end

    assign o_Score      = r_Score;
    assign o_Level_Up   = r_Level_Up;
    assign o_Lives      = r_Lives;
    assign o_Frog_Reset = r_Frog_Reset;
    assign o_Game_Over  = r_Game_Over;
    assign o_State      = r_State;

endmodule

// File: tb/tb_level_controller.sv
// tb/tb_level_controller.sv - self-checking bench for level_controller
module tb_level_controller;

    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] row;
    logic       coll;
    logic [3:0] score;
    logic       level_up;
    logic [3:0] reverse;
    logic [1:0] lives;
    logic       frog_reset;
    logic       game_over;
    logic [1:0] state;

    always #5 clk = ~clk;

    level_controller #(
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Start      (start),
        .i_Frog_Row   (row),
        .i_Collision  (coll),
        .o_Score      (score),
        .o_Level_Up   (level_up),
        .o_Reverse    (reverse),
        .o_Lives      (lives),
        .o_Frog_Reset (frog_reset),
        .o_Game_Over  (game_over),
        .o_State      (state)
    );

    typedef struct {
        logic [1:0] st;
        logic [3:0] score;
        logic [1:0] lives;
        logic [3:0] rev;
        logic       lu;
        logic       fr;
        logic       go;
    } exp_t;

    typedef struct {
        logic       start;
        logic [3:0] row;
        logic       coll;
        int         rep;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk_exp(logic [1:0] st, logic [3:0] sc, logic [1:0] lv,
                                    logic [3:0] rv, logic lu, logic fr, logic go);
        exp_t e;
        e.st = st; e.score = sc; e.lives = lv; e.rev = rv; e.lu = lu; e.fr = fr; e.go = go;
        return e;
    endfunction

    function automatic vec_t mk_vec(logic s, logic [3:0] r, logic c, int rep, exp_t e);
        vec_t v;
        v.start = s; v.row = r; v.coll = c; v.rep = rep; v.e = e;
        return v;
    endfunction

    function automatic logic [3:0] lfsr_model(logic [3:0] v);
        return {v[2:0], v[3] ^ v[2]};
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic compare_outputs(string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".state"},      8'(state),      8'(e.st));
            chk({tag, ".score"},      8'(score),      8'(e.score));
            chk({tag, ".lives"},      8'(lives),      8'(e.lives));
            chk({tag, ".reverse"},    8'(reverse),    8'(e.rev));
            chk({tag, ".level_up"},   8'(level_up),   8'(e.lu));
            chk({tag, ".frog_reset"}, 8'(frog_reset), 8'(e.fr));
            chk({tag, ".game_over"},  8'(game_over),  8'(e.go));
        end
    endtask

    task automatic step(logic s, logic [3:0] r, logic c);
        start = s;
        row   = r;
        coll  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(vec_t v, string tag);
        for (int i = 0; i < v.rep; i++) begin
            if (i == v.rep - 1) sb_q.push_back(v.e);
            step(v.start, v.row, v.coll);
            if (i == v.rep - 1) compare_outputs(tag);
        end
    endtask

    vec_t       tbl[19];
    exp_t       rst_exp;
    logic [3:0] m_score;
    logic [3:0] m_rev;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        row   = 4'd7;
        coll  = 1'b0;
        rst_exp = mk_exp(2'd0, 4'd0, 2'd3, 4'b1001, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(rst_exp);
        compare_outputs("reset");
        rst = 1'b0;

        // start, respawn ignoring inputs, goals (one held across respawn),
        // collision+goal, lives down to game over, restart
        tbl[0]  = mk_vec(1, 7, 0, 1, mk_exp(2, 0, 3, 4'b1001, 1, 1, 0));
        tbl[1]  = mk_vec(0, 0, 1, 1, mk_exp(2, 0, 3, 4'b1001, 0, 0, 0));
        tbl[2]  = mk_vec(1, 7, 0, 6, mk_exp(2, 0, 3, 4'b1001, 0, 0, 0));
        tbl[3]  = mk_vec(0, 7, 0, 1, mk_exp(1, 0, 3, 4'b1001, 0, 0, 0));
        tbl[4]  = mk_vec(0, 0, 0, 1, mk_exp(2, 1, 3, 4'b0011, 1, 1, 0));
        tbl[5]  = mk_vec(0, 0, 0, 1, mk_exp(2, 1, 3, 4'b0011, 0, 0, 0));
        tbl[6]  = mk_vec(0, 0, 0, 6, mk_exp(2, 1, 3, 4'b0011, 0, 0, 0));
        tbl[7]  = mk_vec(0, 0, 0, 1, mk_exp(1, 1, 3, 4'b0011, 0, 0, 0));
        tbl[8]  = mk_vec(0, 0, 0, 1, mk_exp(2, 2, 3, 4'b0110, 1, 1, 0));
        tbl[9]  = mk_vec(0, 7, 0, 8, mk_exp(1, 2, 3, 4'b0110, 0, 0, 0));
        tbl[10] = mk_vec(0, 0, 1, 1, mk_exp(2, 2, 2, 4'b0110, 0, 1, 0));
        tbl[11] = mk_vec(0, 7, 0, 8, mk_exp(1, 2, 2, 4'b0110, 0, 0, 0));
        tbl[12] = mk_vec(0, 7, 1, 1, mk_exp(2, 2, 1, 4'b0110, 0, 1, 0));
        tbl[13] = mk_vec(0, 7, 0, 8, mk_exp(1, 2, 1, 4'b0110, 0, 0, 0));
        tbl[14] = mk_vec(0, 7, 1, 1, mk_exp(3, 2, 0, 4'b0110, 0, 0, 1));
        tbl[15] = mk_vec(0, 7, 0, 3, mk_exp(3, 2, 0, 4'b0110, 0, 0, 1));
        tbl[16] = mk_vec(0, 0, 1, 1, mk_exp(3, 2, 0, 4'b0110, 0, 0, 1));
        tbl[17] = mk_vec(1, 7, 0, 1, mk_exp(2, 0, 3, 4'b1001, 1, 1, 0));
        tbl[18] = mk_vec(0, 7, 0, 8, mk_exp(1, 0, 3, 4'b1001, 0, 0, 0));

        for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // 16 goals: score saturates at 15 while the LFSR keeps stepping
        m_score = 4'd0;
        m_rev   = 4'b1001;
        for (int g = 1; g <= 16; g++) begin
            m_score = (m_score == 4'd15) ? 4'd15 : m_score + 4'd1;
            m_rev   = lfsr_model(m_rev);
            apply(mk_vec(0, 0, 0, 1, mk_exp(2, m_score, 3, m_rev, 1, 1, 0)), $sformatf("goal%0d", g));
            apply(mk_vec(0, 7, 0, 8, mk_exp(1, m_score, 3, m_rev, 0, 0, 0)), $sformatf("goal%0d_hold", g));
        end

        // reset while level-up/frog-reset pulses are high drops them at once
        m_rev = lfsr_model(m_rev);
        apply(mk_vec(0, 0, 0, 1, mk_exp(2, 15, 3, m_rev, 1, 1, 0)), "pulse_goal");
        rst = 1'b1;
        #2;
        sb_q.push_back(rst_exp);
        compare_outputs("async_rst_pulse");
        rst = 1'b0;
        apply(mk_vec(0, 7, 0, 1, rst_exp), "post_rst_idle");

        // reset in RESPAWN with hold counter at 5, then clean restart
        apply(mk_vec(1, 7, 0, 1, mk_exp(2, 0, 3, 4'b1001, 1, 1, 0)), "restart1");
        apply(mk_vec(0, 7, 0, 5, mk_exp(2, 0, 3, 4'b1001, 0, 0, 0)), "hold5");
        #2;
        rst = 1'b1;
        #1;
        sb_q.push_back(rst_exp);
        compare_outputs("async_rst_respawn");
        rst = 1'b0;
        apply(mk_vec(0, 7, 0, 1, rst_exp), "post_rst_idle2");
        apply(mk_vec(1, 7, 0, 1, mk_exp(2, 0, 3, 4'b1001, 1, 1, 0)), "restart2");
        apply(mk_vec(0, 7, 0, 7, mk_exp(2, 0, 3, 4'b1001, 0, 0, 0)), "restart2_hold");
        apply(mk_vec(0, 7, 0, 1, mk_exp(1, 0, 3, 4'b1001, 0, 0, 0)), "restart2_play");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
